// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one variable-latency memory port between fetch and data.
// Data has priority; a streak limit forces fetch through after repeated data wins.
module mem_arbiter #(
  parameter int unsigned MAX_DATA_STREAK = 4,
  parameter int unsigned TIMEOUT         = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        owner,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_t;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);
  localparam logic [7:0] TCNT_LAST  = 8'(TIMEOUT - 1);

  state_t      state;
  logic [3:0]  streak;
  logic [7:0]  tcnt;
  logic        grant_dm;
  logic        grant_if;
  logic        done;
  logic [31:0] rsp_data;

  always_comb begin
    grant_dm = dm_req && !(if_req && streak == STREAK_MAX);
    grant_if = if_req && !grant_dm;
    // ack on the terminal count still counts as a normal completion
    done     = mem_ack || tcnt == TCNT_LAST;
    rsp_data = '0;
    if (mem_ack && !mem_we) rsp_data = mem_rdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      streak    <= '0;
      tcnt      <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      owner     <= 1'b0;
      err       <= 1'b0;
      if_ready  <= 1'b0;
      dm_ready  <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      if_ready <= 1'b0;
      dm_ready <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant_dm || grant_if) begin
            state     <= ISSUE;
            mem_req   <= 1'b1;
            owner     <= grant_dm;
            mem_we    <= grant_dm & dm_we;
            mem_addr  <= grant_dm ? dm_addr : if_addr;
            mem_wdata <= grant_dm ? dm_wdata : '0;
            if (grant_if)
              streak <= '0;
            else if (if_req && streak != STREAK_MAX)
              streak <= streak + 4'd1;
          end
        end
        ISSUE: begin
          if (done) begin
            state   <= RESP;
            mem_req <= 1'b0;
            tcnt    <= '0;
            if (!mem_ack) err <= 1'b1;
            if (owner) begin
              dm_ready <= 1'b1;
              dm_rdata <= rsp_data;
            end else begin
              if_ready <= 1'b1;
              if_rdata <= rsp_data;
            end
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random traffic against a transaction-level
// model of arbitration, latency, timeout, stickiness and reset.
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam int MAXS = 4;
  localparam int TMO  = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [31:0] dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic [31:0] dm_rdata;
  logic        dm_ready;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        owner;
  logic        err;

  always #5 clk = ~clk;

  mem_arbiter #(
    .MAX_DATA_STREAK(MAXS),
    .TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .if_req(if_req),
    .if_addr(if_addr),
    .if_rdata(if_rdata),
    .if_ready(if_ready),
    .dm_req(dm_req),
    .dm_we(dm_we),
    .dm_addr(dm_addr),
    .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata),
    .dm_ready(dm_ready),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack(mem_ack),
    .owner(owner),
    .err(err)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'h100) return 32'h2002000A;
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  // transaction model
  typedef enum {M_IDLE, M_BUSY, M_RESP} mst_t;
  mst_t        m_st;
  int          m_streak;
  int          m_wait;
  bit          m_owner;
  bit          m_we;
  bit          m_err;
  logic [31:0] m_addr;
  logic [31:0] m_wd;
  logic [31:0] m_data;
  logic [31:0] m_if_rd;
  logic [31:0] m_dm_rd;
  bit          glog[$];

  // request/ack values seen by the DUT at the next edge
  bit s_if, s_dm, s_ack;

  // memory device and traffic knobs
  int lat_cnt = 0;
  int cur_lat = 1;
  int lat_fix = 1;
  bit lat_rand = 0;
  bit no_ack = 0;
  bit spur = 0;
  int if_pct = 0;
  int dm_pct = 0;

  task automatic model_reset();
    m_st = M_IDLE;
    m_streak = 0;
    m_wait = 0;
    m_owner = 0;
    m_we = 0;
    m_err = 0;
    m_addr = '0;
    m_wd = '0;
    m_data = '0;
    m_if_rd = '0;
    m_dm_rd = '0;
  endtask

  task automatic check_outs();
    chk("mem_req", mem_req, m_st == M_BUSY);
    chk("if_ready", if_ready, m_st == M_RESP && !m_owner);
    chk("dm_ready", dm_ready, m_st == M_RESP && m_owner);
    chk("if_rdata", if_rdata, m_if_rd);
    chk("dm_rdata", dm_rdata, m_dm_rd);
    chk("owner", owner, m_owner);
    chk("err", err, m_err);
    chk("mem_we", mem_we, m_we);
    chk("mem_addr", mem_addr, m_addr);
    if (m_owner) chk("mem_wdata", mem_wdata, m_wd);
  endtask

  function automatic int pick_lat();
    case ($urandom_range(9))
      0, 1, 2: return 1;
      3, 4:    return 2;
      5:       return 3;
      6:       return 4;
      7:       return 5;
      8:       return TMO;
      default: return TMO + 4;
    endcase
  endfunction

  task automatic drive();
    // requesters drop req at the end of their ready cycle
    if (m_st == M_RESP) begin
      if (m_owner) dm_req = 0;
      else if_req = 0;
    end
    if (!if_req && int'($urandom_range(99)) < if_pct) begin
      if_req = 1;
      if_addr = $urandom;
    end
    if (!dm_req && int'($urandom_range(99)) < dm_pct) begin
      dm_req = 1;
      dm_we = $urandom_range(1);
      dm_addr = $urandom;
      dm_wdata = $urandom;
    end
    if (mem_req) begin
      if (lat_cnt == 0) cur_lat = lat_rand ? pick_lat() : lat_fix;
      lat_cnt++;
      mem_ack = !no_ack && lat_cnt == cur_lat;
    end else begin
      lat_cnt = 0;
      mem_ack = spur && $urandom_range(7) == 0;
    end
    mem_rdata = mem_ack ? mem_fn(mem_addr) : $urandom;
    s_if = if_req;
    s_dm = dm_req;
    s_ack = mem_ack;
  endtask

  task automatic cyc();
    bit wd;
    @(negedge clk);
    case (m_st)
      M_IDLE: begin
        if (s_if || s_dm) begin
          wd = s_dm && !(s_if && m_streak >= MAXS);
          m_owner = wd;
          m_we = wd && dm_we;
          m_addr = wd ? dm_addr : if_addr;
          if (wd) m_wd = dm_wdata;
          if (!wd) m_streak = 0;
          else if (s_if && m_streak < MAXS) m_streak++;
          glog.push_back(wd);
          m_wait = 0;
          m_st = M_BUSY;
        end
      end
      M_BUSY: begin
        if (s_ack) begin
          m_data = m_we ? 32'h0 : mem_fn(m_addr);
          m_st = M_RESP;
        end else begin
          m_wait++;
          if (m_wait == TMO) begin
            m_data = 32'h0;
            m_err = 1;
            m_st = M_RESP;
          end
        end
        if (m_st == M_RESP) begin
          if (m_owner) m_dm_rd = m_data;
          else m_if_rd = m_data;
        end
      end
      default: m_st = M_IDLE;
    endcase
    check_outs();
    drive();
  endtask

  task automatic run_quiet(input int budget);
    int n;
    n = 0;
    while ((if_req || dm_req || m_st != M_IDLE) && n < budget) begin
      cyc();
      n++;
    end
    chk("quiet_budget", n < budget, 1);
  endtask

  task automatic raise_if(input logic [31:0] a);
    if_req = 1;
    if_addr = a;
    s_if = 1;
  endtask

  task automatic raise_dm(input logic w, input logic [31:0] a,
                          input logic [31:0] d);
    dm_req = 1;
    dm_we = w;
    dm_addr = a;
    dm_wdata = d;
    s_dm = 1;
  endtask

  // asynchronous reset away from the clock edge, held across one edge
  task automatic do_reset();
    @(negedge clk);
    #2 rst = 0;
    if_req = 0;
    dm_req = 0;
    dm_we = 0;
    mem_ack = 0;
    lat_cnt = 0;
    s_if = 0;
    s_dm = 0;
    s_ack = 0;
    model_reset();
    #1;
    check_outs();
    chk("rst_wdata", mem_wdata, 32'h0);
    @(negedge clk);
    check_outs();
    rst = 1;
  endtask

  initial begin
    model_reset();
    s_if = 0;
    s_dm = 0;
    s_ack = 0;
    do_reset();

    // single fetch, ack three cycles after mem_req
    lat_fix = 3;
    raise_if(32'h100);
    run_quiet(40);
    chk("a_if_rdata", if_rdata, 32'h2002000A);
    chk("a_mem_addr", mem_addr, 32'h100);

    // data write, immediate ack
    lat_fix = 1;
    raise_dm(1'b1, 32'h40, 32'hCAFEF00D);
    run_quiet(40);
    chk("b_mem_we", mem_we, 1);
    chk("b_wdata", mem_wdata, 32'hCAFEF00D);
    chk("b_dm_rdata", dm_rdata, 32'h0);

    // simultaneous requests: data first, then fetch
    glog.delete();
    raise_if(32'h200);
    raise_dm(1'b0, 32'h300, 32'h0);
    run_quiet(60);
    chk("c_ngrants", glog.size(), 2);
    if (glog.size() >= 2) begin
      chk("c_first", glog[0], 1);
      chk("c_second", glog[1], 0);
    end

    // starvation guard
    do_reset();
    glog.delete();
    if_pct = 100;
    dm_pct = 100;
    for (int i = 0; i < 200 && glog.size() < 6; i++) cyc();
    if_pct = 0;
    dm_pct = 0;
    run_quiet(60);
    chk("d_ngrants", glog.size() >= 6, 1);
    if (glog.size() >= 6) begin
      chk("d_g0", glog[0], 1);
      chk("d_g1", glog[1], 1);
      chk("d_g2", glog[2], 1);
      chk("d_g3", glog[3], 1);
      chk("d_g4", glog[4], 0);
      chk("d_g5", glog[5], 1);
    end

    // timeout after a fetch that left nonzero data behind
    do_reset();
    lat_fix = 2;
    raise_if(32'h100);
    run_quiet(40);
    chk("e_pre_rdata", if_rdata, 32'h2002000A);
    no_ack = 1;
    raise_if(32'h500);
    run_quiet(40);
    no_ack = 0;
    chk("e_err", err, 1);
    chk("e_if_rdata", if_rdata, 32'h0);
    for (int i = 0; i < 5; i++) cyc();
    raise_dm(1'b0, 32'h600, 32'h0);
    run_quiet(40);
    chk("e_err_sticky", err, 1);

    // random mixed traffic with spurious acks and edge latencies
    do_reset();
    glog.delete();
    lat_rand = 1;
    spur = 1;
    if_pct = 30;
    dm_pct = 40;
    for (int i = 0; i < 3000; i++) cyc();
    if_pct = 0;
    dm_pct = 0;
    run_quiet(100);
    spur = 0;
    lat_rand = 0;
    chk("f_grants", glog.size() > 50, 1);

    // reset in the middle of an outstanding data read
    no_ack = 1;
    raise_dm(1'b0, 32'h700, 32'h0);
    for (int i = 0; i < 3; i++) cyc();
    chk("g_busy", mem_req, 1);
    do_reset();
    no_ack = 0;
    for (int i = 0; i < 3; i++) cyc();
    lat_fix = 2;
    raise_if(32'h100);
    run_quiet(40);
    chk("g_if_rdata", if_rdata, 32'h2002000A);
    chk("g_err", err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
